// File: rtl/pc_fetch_unit.sv
// Program-counter fetch unit: issues one instruction-memory request at a time,
// holds the returned word for the downstream stage, and follows redirects
// (including ones that arrive while a request is still outstanding).
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] next_pc,
    input  logic        redirect,
    input  logic        stall,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] seq_pc,
    output logic [31:0] pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic        misalign
);

    localparam int unsigned XLEN     = 32;
    localparam int unsigned INST_LEN = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2,
        S_ERR  = 2'd3
    } state_e;

    state_e            state_q,      state_d;
    logic [XLEN-1:0]   pc_q,         pc_d;
    logic [XLEN-1:0]   inst_q,       inst_d;
    logic              inst_valid_q, inst_valid_d;
    logic              misalign_q,   misalign_d;
    logic              imem_req_q,   imem_req_d;
    logic              pend_q,       pend_d;
    logic [XLEN-1:0]   pend_pc_q,    pend_pc_d;

    logic              jump;
    logic [XLEN-1:0]   jump_tgt;

    // Sequential successor of the current pc, wraps modulo 2^32
    assign seq_pc = pc_q + XLEN'(INST_LEN);

    // Fetch address is the held pc, so it cannot move while a request waits
    assign imem_addr  = pc_q;
    assign pc         = pc_q;
    assign imem_req   = imem_req_q;
    assign inst       = inst_q;
    assign inst_valid = inst_valid_q;
    assign misalign   = misalign_q;

    // Next-state logic: state transitions, pending redirect, pc/inst updates
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        inst_d       = inst_q;
        inst_valid_d = inst_valid_q;
        misalign_d   = misalign_q;
        pend_d       = pend_q;
        pend_pc_d    = pend_pc_q;
        jump         = 1'b0;
        jump_tgt     = '0;

        unique case (state_q)
            S_IDLE: begin
                // Any ack seen here belongs to an abandoned request
                if (redirect) begin
                    jump     = 1'b1;
                    jump_tgt = next_pc;
                end else begin
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (imem_ack) begin
                    pend_d = 1'b0;
                    if (redirect) begin
                        jump     = 1'b1;
                        jump_tgt = next_pc;
                    end else if (pend_q) begin
                        jump     = 1'b1;
                        jump_tgt = pend_pc_q;
                    end else begin
                        inst_d       = imem_rdata;
                        inst_valid_d = 1'b1;
                        state_d      = S_HOLD;
                    end
                end else if (redirect) begin
                    // Request must stay stable; remember latest target for the ack
                    pend_d    = 1'b1;
                    pend_pc_d = next_pc;
                end
            end
            S_HOLD: begin
                if (redirect) begin
                    jump     = 1'b1;
                    jump_tgt = next_pc;
                end else if (!stall) begin
                    pc_d         = seq_pc;
                    inst_valid_d = 1'b0;
                    state_d      = S_REQ;
                end
            end
            S_ERR: begin
                if (redirect) begin
                    jump     = 1'b1;
                    jump_tgt = next_pc;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Common redirect handling: aligned targets refetch, misaligned park in ERR
        if (jump) begin
            pc_d         = jump_tgt;
            inst_valid_d = 1'b0;
            if (jump_tgt[1:0] != 2'b00) begin
                misalign_d = 1'b1;
                state_d    = S_ERR;
            end else begin
                misalign_d = 1'b0;
                state_d    = S_REQ;
            end
        end

        imem_req_d = (state_d == S_REQ);
    end

    // State and datapath registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q      <= S_IDLE;
            pc_q         <= RESET_PC;
            inst_q       <= '0;
            inst_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
            imem_req_q   <= 1'b0;
            pend_q       <= 1'b0;
            pend_pc_q    <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            inst_q       <= inst_d;
            inst_valid_q <= inst_valid_d;
            misalign_q   <= misalign_d;
            imem_req_q   <= imem_req_d;
            pend_q       <= pend_d;
            pend_pc_q    <= pend_pc_d;
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed scenarios followed by random traffic,
// all checked against a transaction-level reference model.
module tb_pc_fetch_unit;

    localparam logic [31:0] RPC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] next_pc;
    logic        redirect;
    logic        stall;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] seq_pc, pc, imem_addr, inst;
    logic        imem_req, inst_valid, misalign;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [31:0] m_pc, m_inst, m_pend;
    bit m_iv, m_mis, m_req, m_hold, m_err, m_idle, m_pv;

    always #5 clk = ~clk;

    pc_fetch_unit #(.RESET_PC(RPC)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .next_pc    (next_pc),
        .redirect   (redirect),
        .stall      (stall),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .seq_pc     (seq_pc),
        .pc         (pc),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .inst_valid (inst_valid),
        .inst       (inst),
        .misalign   (misalign)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic void m_reset();
        m_pc = RPC; m_inst = '0; m_pend = '0;
        m_iv = 0; m_mis = 0; m_req = 0; m_hold = 0; m_err = 0; m_pv = 0;
        m_idle = 1;
    endfunction

    // Follow a redirect: misaligned targets park in error, others refetch
    function automatic void m_goto(input logic [31:0] t);
        m_pc = t; m_iv = 0; m_hold = 0; m_pv = 0;
        if ((t % 4) != 0) begin
            m_err = 1; m_mis = 1; m_req = 0;
        end else begin
            m_err = 0; m_mis = 0; m_req = 1;
        end
    endfunction

    function automatic void m_step();
        if (!resetn) return;
        if (m_idle) begin
            m_idle = 0;
            if (redirect) m_goto(next_pc);
            else m_req = 1;
        end else if (m_err) begin
            if (redirect) m_goto(next_pc);
        end else if (m_req) begin
            if (imem_ack) begin
                if (redirect) m_goto(next_pc);
                else if (m_pv) m_goto(m_pend);
                else begin
                    m_inst = imem_rdata; m_iv = 1; m_hold = 1; m_req = 0;
                end
            end else if (redirect) begin
                m_pv = 1; m_pend = next_pc;
            end
        end else if (m_hold) begin
            if (redirect) m_goto(next_pc);
            else if (!stall) begin
                m_pc = m_pc + 32'd4; m_iv = 0; m_hold = 0; m_req = 1;
            end
        end
    endfunction

    task automatic cmp_all(input string tag);
        chk({tag, ".pc"},       pc,                  m_pc);
        chk({tag, ".seq_pc"},   seq_pc,              m_pc + 32'd4);
        chk({tag, ".req"},      32'(imem_req),       32'(m_req));
        if (m_req) chk({tag, ".addr"}, imem_addr,    m_pc);
        chk({tag, ".iv"},       32'(inst_valid),     32'(m_iv));
        chk({tag, ".inst"},     inst,                m_inst);
        chk({tag, ".mis"},      32'(misalign),       32'(m_mis));
    endtask

    // One clock: drive inputs, advance the model at the edge, check just after
    task automatic step(input string tag, input bit rd, input logic [31:0] np,
                        input bit st, input bit ak, input logic [31:0] dat);
        redirect = rd; next_pc = np; stall = st; imem_ack = ak; imem_rdata = dat;
        @(posedge clk);
        m_step();
        #1;
        cmp_all(tag);
    endtask

    task automatic idle_step(input string tag);
        step(tag, 0, 32'h0, 0, 0, 32'h0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 resetn = 1'b0;
        m_reset();
        #1;
        cmp_all(tag);
        chk({tag, ".req0"}, 32'(imem_req), 32'd0);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    initial begin
        logic [31:0] np;
        bit rd, st, ak;

        resetn = 1'b0; redirect = 0; next_pc = '0; stall = 0;
        imem_ack = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        m_reset();
        #3;
        cmp_all("reset");
        #9 resetn = 1'b1;

        // Ack during the idle cycle is ignored
        step("idle_ack", 0, 32'h0, 0, 1, 32'hDEAD_BEEF);
        chk("idle_ack.iv0", 32'(inst_valid), 32'd0);
        chk("idle_ack.addr0", imem_addr, 32'h0);

        // Three sequential fetches 0,4,8
        for (int n = 0; n < 3; n++) begin
            idle_step("seq_wait");
            step("seq_ack", 0, 32'h0, 0, 1, 32'h1111_0000 + 32'(n));
            chk("seq_inst", inst, 32'h1111_0000 + 32'(n));
            chk("seq_pc_hold", pc, 32'(4 * n));
            if (n < 2) idle_step("seq_next");
        end

        // Stall in HOLD at pc=8
        for (int k = 0; k < 5; k++) begin
            step("stall", 0, 32'h0, 1, 0, 32'h0);
            chk("stall.pc8", pc, 32'h8);
            chk("stall.noreq", 32'(imem_req), 32'd0);
        end
        idle_step("stall_rel");
        chk("stall_rel.addr12", imem_addr, 32'hC);
        step("ack12", 0, 32'h0, 0, 1, 32'h2222_000C);

        // Back to pc=4, then redirect while the request is outstanding
        step("to4", 1, 32'h4, 0, 0, 32'h0);
        step("pend_set", 1, 32'h100, 0, 0, 32'h0);
        chk("pend.addr4", imem_addr, 32'h4);
        idle_step("pend_w1");
        idle_step("pend_w2");
        chk("pend_w2.addr4", imem_addr, 32'h4);
        step("pend_ack", 0, 32'h0, 0, 1, 32'h3333_3333);
        chk("pend_ack.iv0", 32'(inst_valid), 32'd0);
        chk("pend_ack.addr100", imem_addr, 32'h100);

        // Redirect beats stall in HOLD
        step("ack100", 0, 32'h0, 0, 1, 32'h4444_0100);
        step("rd_stall", 1, 32'h40, 1, 0, 32'h0);
        chk("rd_stall.iv0", 32'(inst_valid), 32'd0);
        chk("rd_stall.addr40", imem_addr, 32'h40);

        // Misaligned redirect together with the ack, then recover
        step("mis", 1, 32'h102, 0, 1, 32'h5555_5555);
        chk("mis.flag", 32'(misalign), 32'd1);
        idle_step("mis_hold");
        step("mis_ok", 1, 32'h200, 0, 0, 32'h0);
        chk("mis_ok.flag0", 32'(misalign), 32'd0);
        chk("mis_ok.addr200", imem_addr, 32'h200);

        // Latest pending target wins; misaligned pending waits for the ack
        step("pend_a", 1, 32'h103, 0, 0, 32'h0);
        step("pend_b", 1, 32'h300, 0, 0, 32'h0);
        step("pend_b_ack", 0, 32'h0, 0, 1, 32'h6666_6666);
        chk("pend_b.addr300", imem_addr, 32'h300);
        step("pend_m", 1, 32'h105, 0, 0, 32'h0);
        chk("pend_m.req", 32'(imem_req), 32'd1);
        step("pend_m_ack", 0, 32'h0, 0, 1, 32'h7777_7777);
        chk("pend_m.flag", 32'(misalign), 32'd1);

        // Wrap at the top of the address space
        step("wrap", 1, 32'hFFFF_FFFC, 0, 0, 32'h0);
        chk("wrap.seq0", seq_pc, 32'h0);
        step("wrap_ack", 0, 32'h0, 0, 1, 32'h8888_8888);
        idle_step("wrap_next");
        chk("wrap_next.addr0", imem_addr, 32'h0);

        // Reset in the middle of the request
        pulse_reset("mid_reset");
        step("post_reset_ack", 0, 32'h0, 0, 1, 32'h9999_9999);
        chk("post_reset.iv0", 32'(inst_valid), 32'd0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rd = ($urandom_range(7, 0) == 0);
            np = $urandom;
            if ($urandom_range(4, 0) != 0) np = np & 32'hFFFF_FFFC;
            st = ($urandom_range(2, 0) == 0);
            ak = m_req && ($urandom_range(1, 0) == 1);
            step("rand", rd, np, st, ak, $urandom);
            if (i == 300) pulse_reset("rand_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
